// File: rtl/opnd_skew_feeder_pkg.sv
// Shared types for the operand feeders, the PE-array top and the array controller.
// Holds the feeder FSM encoding, the default lane geometry and a lane-extract helper.
package opnd_skew_feeder_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int LANES_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [DWIDTH_DEF-1:0] lane_slice(
    input logic [LANES_DEF*DWIDTH_DEF-1:0] bus,
    input int unsigned                     lane
  );
    return bus[lane*DWIDTH_DEF +: DWIDTH_DEF];
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Single-lane data+valid shift register of DEPTH stages; advances only when en_i is high.
// Invalid entries are carried as zero data so idle lanes present a clean zero.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              vld_i,
  input  logic [DWIDTH-1:0] dat_i,
  output logic              vld_o,
  output logic [DWIDTH-1:0] dat_o
);

  logic [DWIDTH-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      dat_q[0] <= vld_i ? dat_i : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/opnd_skew_feeder.sv
// Streams K operand SRAM rows into the PE edge with lane i delayed i extra cycles;
// K+LANES+1 cycles START-to-DONE, STALL freezes everything except the SRAM return capture.
module opnd_skew_feeder
  import opnd_skew_feeder_pkg::*;
#(
  parameter int SRAM_AWIDTH     = 10,
  parameter int LANES           = LANES_DEF,
  parameter int LANES_LOG2      = 5,
  parameter int DWIDTH          = DWIDTH_DEF,
  parameter int MAX_K_SIZE_LOG2 = 9
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       STALL,
  input  logic [MAX_K_SIZE_LOG2-1:0] K_SIZE_in,
  input  logic [SRAM_AWIDTH-1:0]     BASE_ADDR_in,
  output logic [SRAM_AWIDTH-1:0]     SRAM_ADDR_out,
  output logic                       SRAM_REN_out,
  input  logic [LANES*DWIDTH-1:0]    SRAM_DATA_in,
  output logic [LANES*DWIDTH-1:0]    PE_DATA_out,
  output logic [LANES-1:0]           PE_VALID_out,
  output logic                       BUSY_out,
  output logic                       DONE_out
);

  state_e state_q, state_d;

  logic [SRAM_AWIDTH-1:0]     base_q, base_d;
  logic [MAX_K_SIZE_LOG2-1:0] k_q, k_d;
  logic [MAX_K_SIZE_LOG2-1:0] row_q, row_d;
  logic [LANES_LOG2-1:0]      drain_q, drain_d;

  logic                    ren_q;
  logic                    pend_q;
  logic [LANES*DWIDTH-1:0] cap_q;
  logic                    feed_vld;
  logic [LANES*DWIDTH-1:0] feed_dat;

  logic accept;
  logic last_row;
  logic drain_end;

  assign accept    = (state_q == ST_IDLE) && START;
  assign last_row  = (row_q == k_q - MAX_K_SIZE_LOG2'(1));
  assign drain_end = (drain_q == LANES_LOG2'(LANES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = (K_SIZE_in == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (!STALL && last_row) state_d = ST_DRAIN;
      ST_DRAIN: if (!STALL && drain_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    SRAM_REN_out  = 1'b0;
    SRAM_ADDR_out = '0;
    BUSY_out      = 1'b0;
    DONE_out      = 1'b0;
    case (state_q)
      ST_READ: begin
        SRAM_REN_out  = !STALL;
        SRAM_ADDR_out = base_q + SRAM_AWIDTH'(row_q);
        BUSY_out      = 1'b1;
      end
      ST_DRAIN: BUSY_out = 1'b1;
      ST_DONE:  DONE_out = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    k_d     = k_q;
    row_d   = row_q;
    drain_d = drain_q;
    if (accept) begin
      base_d  = BASE_ADDR_in;
      k_d     = K_SIZE_in;
      row_d   = '0;
      drain_d = '0;
    end
    if (SRAM_REN_out) row_d = row_q + MAX_K_SIZE_LOG2'(1);
    if ((state_q == ST_DRAIN) && !STALL) drain_d = drain_q + LANES_LOG2'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base_q  <= '0;
      k_q     <= '0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      base_q  <= base_d;
      k_q     <= k_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  // Returning read data is parked here when STALL blocks the skew stages from taking it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ren_q  <= 1'b0;
      pend_q <= 1'b0;
      cap_q  <= '0;
    end else begin
      ren_q  <= SRAM_REN_out;
      pend_q <= STALL && (pend_q || ren_q);
      if (ren_q) cap_q <= SRAM_DATA_in;
    end
  end

  assign feed_vld = pend_q || ren_q;
  assign feed_dat = pend_q ? cap_q : (ren_q ? SRAM_DATA_in : '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (i + 1),
      .DWIDTH (DWIDTH)
    ) u_skew (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (!STALL),
      .vld_i (feed_vld),
      .dat_i (feed_dat[i*DWIDTH +: DWIDTH]),
      .vld_o (PE_VALID_out[i]),
      .dat_o (PE_DATA_out[i*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: tb/tb_opnd_skew_feeder.sv
// Directed and randomized streams checked cycle-by-cycle against a queue-based model
// of the feeder (rows issued in order, each lane i delayed i further pipeline advances).
module tb_opnd_skew_feeder;
  import opnd_skew_feeder_pkg::*;

  localparam int LANES = 32;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  logic           clk = 1'b0;
  logic           RST = 1'b0;
  logic           START = 1'b0;
  logic           STALL = 1'b0;
  logic [8:0]     K_SIZE_in = '0;
  logic [9:0]     BASE_ADDR_in = '0;
  logic [9:0]     SRAM_ADDR_out;
  logic           SRAM_REN_out;
  logic [W-1:0]   sram_q = '0;
  logic [W-1:0]   PE_DATA_out;
  logic [LANES-1:0] PE_VALID_out;
  logic           BUSY_out;
  logic           DONE_out;

  always #5 clk = ~clk;

  opnd_skew_feeder dut (
    .CLK           (clk),
    .RST           (RST),
    .START         (START),
    .STALL         (STALL),
    .K_SIZE_in     (K_SIZE_in),
    .BASE_ADDR_in  (BASE_ADDR_in),
    .SRAM_ADDR_out (SRAM_ADDR_out),
    .SRAM_REN_out  (SRAM_REN_out),
    .SRAM_DATA_in  (sram_q),
    .PE_DATA_out   (PE_DATA_out),
    .PE_VALID_out  (PE_VALID_out),
    .BUSY_out      (BUSY_out),
    .DONE_out      (DONE_out)
  );

  logic [W-1:0] mem [1024];

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // One-cycle-latency SRAM; returns garbage when not read so stray captures show up.
  always @(posedge clk) sram_q <= SRAM_REN_out ? mem[SRAM_ADDR_out] : rand_word();

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit   m_active, m_done;
  int   m_row, m_k, m_base, m_drain;
  ent_t pend[$];
  ent_t hist[$];

  function automatic void model_reset();
    ent_t z;
    z = '0;
    m_active = 0; m_done = 0;
    m_row = 0; m_k = 0; m_base = 0; m_drain = 0;
    pend.delete();
    hist.delete();
    for (int i = 0; i < LANES; i++) hist.push_back(z);
  endfunction

  int         cyc, done_cyc, ren_cnt;
  logic [9:0] addr_obs [64];
  bit         ren_obs [64];
  logic [7:0] l0_obs [64], l31_obs [64];
  bit         l0v_obs [64], l31v_obs [64];

  task automatic cycle(input logic s, input logic st, input int kin, input int bin);
    bit             reading, e_ren;
    logic [9:0]     e_addr;
    logic [W-1:0]   ed;
    logic [LANES-1:0] ev;
    ent_t           e;
    START = s; STALL = st; K_SIZE_in = kin[8:0]; BASE_ADDR_in = bin[9:0];
    reading = m_active && (m_row < m_k);
    e_ren   = reading && !st;
    e_addr  = 10'(m_base + m_row);
    ed = '0; ev = '0;
    for (int i = 0; i < LANES; i++) begin
      e = hist[LANES-1-i];
      if (e.v) begin
        ev[i] = 1'b1;
        ed[i*DW +: DW] = lane_slice(e.d, i);
      end
    end
    @(negedge clk);
    chk("ren", SRAM_REN_out, e_ren);
    if (e_ren) chk("addr", SRAM_ADDR_out, e_addr);
    chk("busy", BUSY_out, m_active);
    chk("done", DONE_out, m_done);
    chk("pe_valid", PE_VALID_out, ev);
    chk("pe_data", PE_DATA_out, ed);
    if (cyc < 64) begin
      addr_obs[cyc] = SRAM_ADDR_out; ren_obs[cyc] = SRAM_REN_out;
      l0_obs[cyc] = PE_DATA_out[7:0]; l0v_obs[cyc] = PE_VALID_out[0];
      l31_obs[cyc] = PE_DATA_out[W-1 -: 8]; l31v_obs[cyc] = PE_VALID_out[LANES-1];
    end
    if (DONE_out && done_cyc < 0) done_cyc = cyc;
    if (SRAM_REN_out) ren_cnt++;
    @(posedge clk);
    if (!st) begin
      e = '0;
      if (pend.size() > 0) e = pend.pop_front();
      hist.push_back(e);
      hist.delete(0);
    end
    if (e_ren) begin
      e.v = 1'b1; e.d = mem[e_addr];
      pend.push_back(e);
    end
    if (m_done) m_done = 0;
    else if (!m_active) begin
      if (s) begin
        if (kin == 0) m_done = 1;
        else begin
          m_active = 1; m_k = kin; m_base = bin; m_row = 0; m_drain = LANES;
        end
      end
    end else if (reading) begin
      if (!st) m_row++;
    end else if (!st) begin
      m_drain--;
      if (m_drain == 0) begin m_active = 0; m_done = 1; end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; STALL = 1'b0;
    #1;
    chk("rst_ren", SRAM_REN_out, 1'b0);
    chk("rst_addr", SRAM_ADDR_out, 10'h0);
    chk("rst_busy", BUSY_out, 1'b0);
    chk("rst_done", DONE_out, 1'b0);
    chk("rst_valid", PE_VALID_out, '0);
    chk("rst_data", PE_DATA_out, '0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    RST = 1'b0;
  endtask

  task automatic run_stream(input int k, input int base, input int st_from, input int st_len,
                            input int pct, input int busy_at);
    int budget;
    int n;
    bit fin;
    budget = 4 * (k + LANES) + 60;
    n = 0; fin = 0;
    cyc = 0; done_cyc = -1; ren_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      addr_obs[i] = '0; ren_obs[i] = 0; l0_obs[i] = '0; l0v_obs[i] = 0;
      l31_obs[i] = '0; l31v_obs[i] = 0;
    end
    while (!fin && n < budget) begin
      logic s, st;
      s  = (n == 0) || (n == busy_at);
      st = (n != 0) && (done_cyc < 0) &&
           ((n >= st_from && n < st_from + st_len) || (int'($urandom_range(99)) < pct));
      cycle(s, st, (n == 0) ? k : 5, (n == 0) ? base : 'h155);
      if (done_cyc >= 0 && n > done_cyc) fin = 1;
      n++;
    end
    chk("stream_completes", fin, 1'b1);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = rand_word();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < LANES; i++) mem[16 + r][i*DW +: DW] = 8'(16 * r + i);

    #2;
    do_reset();

    // Basic stream
    run_stream(3, 'h010, -1, 0, 0, -1);
    chk("b_rd0", {ren_obs[1], addr_obs[1]}, {1'b1, 10'h010});
    chk("b_rd1", {ren_obs[2], addr_obs[2]}, {1'b1, 10'h011});
    chk("b_rd2", {ren_obs[3], addr_obs[3]}, {1'b1, 10'h012});
    chk("b_l0_c2", l0v_obs[2], 1'b0);
    chk("b_l0_c3", {l0v_obs[3], l0_obs[3]}, {1'b1, 8'h00});
    chk("b_l0_c4", {l0v_obs[4], l0_obs[4]}, {1'b1, 8'h10});
    chk("b_l0_c5", {l0v_obs[5], l0_obs[5]}, {1'b1, 8'h20});
    chk("b_l0_c6", l0v_obs[6], 1'b0);
    chk("b_l31_c34", {l31v_obs[34], l31_obs[34]}, {1'b1, 8'h1F});
    chk("b_l31_c35", {l31v_obs[35], l31_obs[35]}, {1'b1, 8'h2F});
    chk("b_l31_c36", {l31v_obs[36], l31_obs[36]}, {1'b1, 8'h3F});
    chk("b_done_cyc", 32'(done_cyc), 32'd36);

    // Address wrap
    run_stream(3, 'h3FF, -1, 0, 0, -1);
    chk("w_rd0", {ren_obs[1], addr_obs[1]}, {1'b1, 10'h3FF});
    chk("w_rd1", {ren_obs[2], addr_obs[2]}, {1'b1, 10'h000});
    chk("w_rd2", {ren_obs[3], addr_obs[3]}, {1'b1, 10'h001});

    // K = 0
    run_stream(0, 'h020, -1, 0, 0, -1);
    chk("k0_done_cyc", 32'(done_cyc), 32'd1);
    chk("k0_no_reads", 32'(ren_cnt), 32'd0);

    // Stall on the return of row 0
    run_stream(2, 'h010, 2, 3, 0, -1);
    chk("s_no_read_c2", ren_obs[2], 1'b0);
    chk("s_rd1_c5", {ren_obs[5], addr_obs[5]}, {1'b1, 10'h011});
    chk("s_l0_c5", l0v_obs[5], 1'b0);
    chk("s_l0_c6", {l0v_obs[6], l0_obs[6]}, {1'b1, 8'h00});
    chk("s_l0_c7", {l0v_obs[7], l0_obs[7]}, {1'b1, 8'h10});
    chk("s_l0_c8", l0v_obs[8], 1'b0);
    chk("s_done_cyc", 32'(done_cyc), 32'd38);

    // START while busy is ignored
    run_stream(3, 'h040, -1, 0, 0, 4);
    chk("busy_reads", 32'(ren_cnt), 32'd3);
    chk("busy_done_cyc", 32'(done_cyc), 32'd36);

    // Reset mid-stream
    cyc = 0; done_cyc = -1; ren_cnt = 0;
    cycle(1'b1, 1'b0, 4, 'h010);
    for (int n = 1; n < 5; n++) cycle(1'b0, 1'b0, 0, 0);
    do_reset();
    cyc = 0; done_cyc = -1;
    for (int n = 0; n < 6; n++) cycle(1'b0, 1'b0, 0, 0);
    chk("rst_no_done", done_cyc < 0, 1'b1);

    // Randomized streams with random stalls and stray STARTs
    for (int t = 0; t < 10; t++) begin
      int k;
      k = int'($urandom_range(1, 48));
      run_stream(k, int'($urandom_range(0, 1023)), -1, 0, int'($urandom_range(0, 40)),
                 int'($urandom_range(1, k + 20)));
    end
    run_stream(1, int'($urandom_range(0, 1023)), -1, 0, 30, 2);
    run_stream(511, int'($urandom_range(0, 1023)), -1, 0, 10, 100);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
